// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} state_t;
  localparam int READ_WAIT_DEF = 3;
  typedef logic midx_t;
endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: 2-way round-robin grant, favouring the master not served last
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  midx_t      last_i,
  output logic [1:0] gnt_o
);
  // one-hot grant; on contention the master opposite to last wins
  always_comb gnt_o = &req_i ? (last_i ? 2'b01 : 2'b10) : (req_i[0] ? 2'b01 : {req_i[1], 1'b0});
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin req/ack front end sequencing a single-ported async memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_WAIT = READ_WAIT_DEF,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [1:0]        grant
);
  localparam int CW = $clog2(READ_WAIT + 1);
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  midx_t             owner_q, owner_d, last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rd0_q, rd0_d, rd1_q, rd1_d;
  logic [1:0]        gnt;
  mem_arb_rr u_rr (.req_i({m1_req, m0_req}), .last_i(last_q), .gnt_o(gnt));
  // state register plus latched transaction fields and per-master read data
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end
  // next state: arbitrate in IDLE, count READ down to capture, single WRITE cycle, ACK back to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    unique case (state_q)
      IDLE: if (|gnt) begin
        owner_d = gnt[1];
        last_d  = gnt[1];
        addr_d  = gnt[1] ? m1_addr : m0_addr;
        wdata_d = gnt[1] ? m1_wdata : m0_wdata;
        cnt_d   = CW'(READ_WAIT);
        state_d = (gnt[1] ? m1_we : m0_we) ? WRITE : READ;
      end
      READ: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ACK;
          rd0_d   = owner_q ? rd0_q : mem_read_data;
          rd1_d   = owner_q ? mem_read_data : rd1_q;
        end
      end
      WRITE:   state_d = ACK;
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded from registered state only, so strobes never follow req
  always_comb begin
    mem_read       = state_q == READ;
    mem_write      = state_q == WRITE;
    mem_addr       = state_q == IDLE ? '0 : addr_q;
    mem_write_data = state_q == IDLE ? '0 : wdata_q;
    grant          = state_q == IDLE ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    m0_ack         = state_q == ACK && !owner_q;
    m1_ack         = state_q == ACK && owner_q;
    m0_rdata       = rd0_q;
    m1_rdata       = rd1_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks against a timestamp-based transaction model
module tb_mem_arbiter;
  localparam int RW = 3;
  logic        clk = 1'b0;
  logic        reset, m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack, mem_read, mem_write;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_write_data, mem_read_data;
  logic [1:0]  grant;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int          cyc, free_at, t_start, t_end, n_chk, n_pass;
  logic        t_act, t_we, t_own, last_m;
  logic [31:0] t_addr, t_wd, t_rdv;
  logic [31:0] m_rd [2];
  int          ackq [$];

  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_addr[9:2]];

  mem_arbiter #(.READ_WAIT(RW), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .grant(grant)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  // one cycle: compare outputs of the current cycle, drive inputs for the next edge, advance the model
  task automatic step(input logic rs, input logic r0, input logic w0, input logic [31:0] a0,
                      input logic [31:0] d0, input logic r1, input logic w1,
                      input logic [31:0] a1, input logic [31:0] d1);
    logic        in_t, wr_p, win;
    logic [31:0] wa, wdd;
    if (t_act && cyc == t_end && !t_we) m_rd[t_own] = t_rdv;
    in_t = t_act && cyc > t_start && cyc <= t_end;
    chk("mem_read", 64'(mem_read), 64'(in_t && !t_we && cyc <= t_start + RW));
    chk("mem_write", 64'(mem_write), 64'(in_t && t_we && cyc == t_start + 1));
    chk("strobe_excl", 64'(mem_read & mem_write), 64'(0));
    chk("m0_ack", 64'(m0_ack), 64'(in_t && cyc == t_end && !t_own));
    chk("m1_ack", 64'(m1_ack), 64'(in_t && cyc == t_end && t_own));
    chk("grant", 64'(grant), in_t ? (t_own ? 64'd2 : 64'd1) : 64'd0);
    chk("mem_addr", 64'(mem_addr), in_t ? 64'(t_addr) : 64'd0);
    chk("mem_wdata", 64'(mem_write_data), in_t ? 64'(t_wd) : 64'd0);
    chk("m0_rdata", 64'(m0_rdata), 64'(m_rd[0]));
    chk("m1_rdata", 64'(m1_rdata), 64'(m_rd[1]));
    if (m0_ack) ackq.push_back(0);
    if (m1_ack) ackq.push_back(1);
    if (t_act && cyc == t_end) t_act = 1'b0;
    wr_p = mem_write;
    wa = mem_addr;
    wdd = mem_write_data;
    reset = rs; m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    if (rs) begin
      t_act = 1'b0; m_rd[0] = '0; m_rd[1] = '0; last_m = 1'b1; free_at = cyc + 1;
    end else if (cyc >= free_at && (r0 || r1)) begin
      win = (r0 && r1) ? !last_m : r1;
      last_m = win; t_act = 1'b1; t_own = win;
      t_we = win ? w1 : w0;
      t_addr = win ? a1 : a0;
      t_wd = win ? d1 : d0;
      t_start = cyc;
      t_end = cyc + (t_we ? 2 : RW + 1);
      free_at = t_end + 1;
      if (t_we) ref_mem[t_addr[9:2]] = t_wd;
      else t_rdv = ref_mem[t_addr[9:2]];
    end
    @(posedge clk);
    if (wr_p) mem[wa[9:2]] = wdd;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[50] = 32'hDEADBEEF; ref_mem[50] = 32'hDEADBEEF;
    reset = 1; m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    n_chk = 0; n_pass = 0; cyc = 0; free_at = 0; t_act = 0; last_m = 1;
    t_start = 0; t_end = 0; t_we = 0; t_own = 0; t_addr = 0; t_wd = 0; t_rdv = 0;
    m_rd[0] = 0; m_rd[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_m0_rdata", 64'(m0_rdata), 64'd0);
    step(0, 1, 0, 32'h000000C8, 0, 0, 0, 0, 0);
    idle(5);
    chk("t1_rdata", 64'(m0_rdata), 64'hDEADBEEF);
    step(0, 0, 0, 0, 0, 1, 1, 32'h000000CC, 32'h12345678);
    idle(3);
    chk("t2_mem51", 64'(mem[51]), 64'h12345678);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    ackq.delete();
    repeat (22) step(0, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
    idle(5);
    chk("t3_nacks", 64'(ackq.size()), 64'd5);
    for (int i = 0; i < 4; i++) chk("t3_order", 64'(ackq[i]), 64'(i % 2));
    step(0, 1, 0, 32'h40, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_read", 64'(mem_read), 64'd0);
    chk("t4_grant", 64'(grant), 64'd0);
    chk("t4_rdata", 64'(m0_rdata), 64'd0);
    idle(3);
    step(0, 0, 0, 0, 0, 1, 1, 32'h000000D0, 32'hCAFEF00D);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_ack", 64'(m1_ack), 64'd0);
    idle(2);
    chk("t5_mem52", 64'(mem[52]), 64'hCAFEF00D);
    ackq.delete();
    repeat (20) step(0, 1, 0, 32'h44, 0, 0, 0, 0, 0);
    chk("t6_nacks", 64'(ackq.size()), 64'd4);
    idle(6);
    repeat (2000) step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                      $urandom, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                      $urandom, $urandom);
    idle(8);
    for (int i = 0; i < 256; i++) chk("mem_final", 64'(mem[i]), 64'(ref_mem[i]));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory controller and arbiter placed between requesters and the single-ported `async_mem` word memory of the multi-cycle MIPS system. It shares the memory between master 0 (the CPU) and master 1 (a loader/DMA/debug port) using round-robin arbitration. It sequences each access with a fixed read wait count that covers the memory's 7 ns combinational read delay. Each master sees a simple req/ack handshake; the memory sees clean, mutually exclusive `mem_read`/`mem_write` strobes.

## Interface
- `READ_WAIT`, 3: cycles `mem_read` is held before `mem_read_data` is sampled. 3 × 2.5 ns ≥ 7 ns. Must be ≥ 1.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `m0_req`, `m1_req`  in  1  access request. Level-sensitive, sampled in IDLE only.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read. Held stable with `req`.
- `m0_addr`, `m1_addr`  in  ADDR_W  byte address. Held stable with `req`.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  DATA_W  read data. Valid in the ack cycle; held until the next read completion for that master.
- `mem_read`  out  1  memory read enable.
- `mem_write`  out  1  memory write enable. Memory writes on the posedge.
- `mem_addr`  out  ADDR_W  latched request address, passed through unmodified.
- `mem_write_data`  out  DATA_W  latched write data.
- `mem_read_data`  in  DATA_W  memory read data (combinational, 7 ns).
- `grant`  out  2  one-hot owner of the current transaction. 00 in IDLE.

## Operation
- FSM states: IDLE, READ, WRITE, ACK.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both request: grant the master not served last. `last` resets to 1, so m0 wins first.
  - On grant: latch addr, we, wdata and the owner, and update `last`.
  - Next state is READ (we = 0) or WRITE (we = 1).
- READ:
  - `mem_read` = 1, down-counter loaded with READ_WAIT.
  - On the edge ending the last READ cycle, capture `mem_read_data` into the owner's rdata register, then go to ACK.
- WRITE: `mem_write` = 1 for exactly one cycle; the memory commits on the edge ending it. Then go to ACK.
- ACK:
  - Owner's ack = 1 and `grant` = owner; both strobes 0.
  - Always returns to IDLE; `req` is ignored in ACK.
  - A master that keeps `req` high into IDLE is issuing a new request.
- `mem_read` and `mem_write` are never both 1. Both are decoded from registered state only, never from `req`.
- `mem_addr` and `mem_write_data` are 0 in IDLE and equal the latched values otherwise.
- Counter width is $clog2(READ_WAIT+1). No wrap: the counter reloads on every READ entry.
- The non-owner's ack is always 0 and its rdata is unchanged.

## Timing
- Reset values: state IDLE, `last` = 1, all acks 0, both rdata 0, `mem_read`/`mem_write` 0, `mem_addr`/`mem_write_data` 0, `grant` 0.
- Latency, counted from the edge that samples `req` in IDLE (cycle 0):
  - Read: `mem_read` high in cycles 1..READ_WAIT; ack in cycle READ_WAIT+1.
  - Write: `mem_write` high in cycle 1; ack in cycle 2.
- Maximum throughput per master stream: one read per READ_WAIT+2 cycles, one write per 3 cycles.
- Reset mid-operation:
  - Reset sampled in any state → IDLE on that edge, no ack, rdata cleared.
  - A WRITE cycle in progress at that edge still commits, because the memory samples the same edge.
- Simultaneous events:
  - Requests arriving while busy are held until IDLE, then arbitrated.
  - A `req` deasserted before being sampled in IDLE is never served.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE, READ, WRITE, ACK), the default READ_WAIT constant, and a master-index type.
- Sub-module `mem_arb_rr`: 2-way round-robin grant logic (req[1:0], last → grant one-hot). Instantiated once.
- All other logic stays in `mem_arbiter`.

## Test plan
- m0 reads 0x000000C8, memory word 50 = 0xDEADBEEF → `mem_read` high cycles 1–3, `m0_ack` in cycle 4, `m0_rdata` = 0xDEADBEEF, `m1_ack` stays 0.
- m1 writes 0x12345678 to 0x000000CC → `mem_write` high only in cycle 1, `m1_ack` in cycle 2, memory word 51 = 0x12345678.
- Both masters request continuously from reset → service order m0, m1, m0, m1; `grant` alternates 01/10; no overlap of strobes.
- Reset asserted in the second READ cycle → next cycle `mem_read` = 0, `grant` = 0, no ack, `m0_rdata` = 0.
- Reset asserted during a WRITE cycle of 0xCAFEF00D to word 52 → memory word 52 = 0xCAFEF00D, no ack.
- m0 holds `req` high with m1 idle → exactly one ack every 5 cycles (READ_WAIT = 3); never two acks in consecutive cycles.
